// File: rtl/sad_final_accumulator.sv
// sad_final_accumulator: resolves redundant sum/carry beats and accumulates NGROUPS of them into one block SAD
module sad_final_accumulator #(
    parameter int W       = 12,
    parameter int NGROUPS = 16,
    parameter int ACC_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_sum,
    input  logic [W-1:0]     in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sad,
    output logic             out_ovf
);
    localparam int CW = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;

    typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [W:0]       p;
    logic             p_valid, p_last;
    logic [ACC_W-1:0] acc;
    logic             ovf_acc;
    logic [ACC_W:0]   sum;
    logic             accept, last_beat;

    // in_ready depends only on registered state and reset, never on out_ready
    assign in_ready  = rst_n & (state == ACCUM);
    assign accept    = in_valid & in_ready & ~clear;
    assign last_beat = cnt == CW'(NGROUPS - 1);
    // one extra bit captures the carry leaving the accumulator MSB
    assign sum       = {1'b0, acc} + (ACC_W + 1)'(p);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_nxt;
    end

    // next-state: ACCUM collects beats, DRAIN folds in the last one, HOLD waits for the consumer
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   state_nxt = (accept && last_beat) ? DRAIN : ACCUM;
            DRAIN:   state_nxt = HOLD;
            HOLD:    state_nxt = out_ready ? ACCUM : HOLD;
            default: state_nxt = ACCUM;
        endcase
        if (clear) state_nxt = ACCUM;
    end

    // stage P: carry-propagate add of the redundant pair, tagged with block position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p       <= '0;
            p_valid <= 1'b0;
            p_last  <= 1'b0;
            cnt     <= '0;
        end else if (clear) begin
            p_valid <= 1'b0;
            cnt     <= '0;
        end else begin
            p_valid <= accept;
            if (accept) begin
                p      <= {1'b0, in_sum} + {1'b0, in_carry};
                p_last <= last_beat;
                cnt    <= last_beat ? '0 : cnt + CW'(1);
            end
        end
    end

    // accumulator: inner beats add into acc, the last beat goes straight to the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            ovf_acc <= 1'b0;
        end else if (clear || state == DRAIN) begin
            acc     <= '0;
            ovf_acc <= 1'b0;
        end else if (p_valid && !p_last) begin
            acc     <= sum[ACC_W-1:0];
            ovf_acc <= ovf_acc | sum[ACC_W];
        end
    end

    // output register: loaded in DRAIN, held through HOLD until the consumer takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sad   <= '0;
            out_ovf   <= 1'b0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (state == DRAIN) begin
            out_valid <= 1'b1;
            out_sad   <= sum[ACC_W-1:0];
            out_ovf   <= ovf_acc | sum[ACC_W];
        end else if (state == HOLD && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sad_final_accumulator.sv
// tb_sad_final_accumulator: scoreboard bench for the block SAD accumulator
module tb_sad_final_accumulator;
    localparam int W = 12, N = 16, AW = 16;

    logic          clk = 0, rst_n = 0, clear = 0, in_valid = 0, out_ready = 1;
    logic [W-1:0]  in_sum = '0, in_carry = '0;
    logic          in_ready, out_valid, out_ovf;
    logic [AW-1:0] out_sad;

    sad_final_accumulator #(.W(W), .NGROUPS(N), .ACC_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_carry(in_carry), .out_valid(out_valid), .out_ready(out_ready),
        .out_sad(out_sad), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    int            tests = 0, fails = 0;
    int            cyc = 0, last_acc_cyc = 0;
    logic          ov_d = 0;
    logic [AW:0]   expq[$];
    logic [AW:0]   e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: latency on each rising out_valid, scoreboard pop on each take
    always @(negedge clk) begin
        cyc++;
        if (out_valid && !ov_d) check("latency", 64'(cyc - last_acc_cyc), 64'd2);
        ov_d = out_valid;
        if (in_valid && in_ready && !clear) last_acc_cyc = cyc;
        if (out_valid && out_ready) begin
            if (expq.size() == 0) check("unexpected_result", 1, 0);
            else begin
                e = expq.pop_front();
                check("out_sad", out_sad, 64'(e[AW-1:0]));
                check("out_ovf", out_ovf, 64'(e[AW]));
            end
        end
    end

    task automatic send(input logic [W-1:0] s, input logic [W-1:0] c, input bit bub);
        int t = 0;
        if (bub) begin
            in_valid = 0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        in_valid = 1; in_sum = s; in_carry = c;
        while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
        if (t >= 100) check("ready_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    task automatic block(input logic [W-1:0] s, input logic [W-1:0] c, input int n, input bit bub);
        for (int i = 0; i < n; i++) send(s, c, bub);
        in_valid = 0;
    endtask

    task automatic wait_result();
        int t = 0;
        while (expq.size() > 0 && t < 200) begin @(posedge clk); #1; t++; end
        check("result_timeout", 64'(expq.size()), 0);
    endtask

    initial begin
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sad", out_sad, 0);
        check("rst_out_ovf", out_ovf, 0);
        #10 rst_n = 1;
        @(posedge clk); #1;
        check("idle_in_ready", in_ready, 1);

        // T1 back-to-back 16x(10,6)
        expq.push_back({1'b0, 16'd256});
        block(10, 6, N, 0);
        wait_result();

        // T2 saturating inputs wrap and flag overflow
        expq.push_back({1'b1, 16'd65504});
        block(12'hfff, 12'hfff, N, 0);
        wait_result();

        // T3 bubbles
        expq.push_back({1'b0, 16'd256});
        block(10, 6, N, 1);
        wait_result();

        // T4 output backpressure
        out_ready = 0;
        expq.push_back({1'b0, 16'd256});
        block(10, 6, N, 0);
        for (int t = 0; t < 50 && !out_valid; t++) begin @(posedge clk); #1; end
        check("hold_valid_seen", out_valid, 1);
        in_valid = 1; in_sum = 3; in_carry = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", out_valid, 1);
            check("hold_out_sad", out_sad, 256);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 0; out_ready = 1;
        @(posedge clk); #1;
        check("take_out_valid", out_valid, 0);
        check("take_in_ready", in_ready, 1);
        expq.push_back({1'b0, 16'd64});
        block(3, 1, N, 0);
        wait_result();

        // T5 clear aborts a partial block
        block(100, 0, 7, 0);
        clear = 1;
        in_valid = 1; in_sum = 100; in_carry = 0;
        @(posedge clk); #1;
        clear = 0; in_valid = 0;
        check("clear_out_valid", out_valid, 0);
        expq.push_back({1'b0, 16'd32});
        block(1, 1, N, 0);
        wait_result();

        // T6 async reset mid-block
        block(5, 5, 9, 0);
        #1 rst_n = 0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_sad", out_sad, 0);
        check("arst_in_ready", in_ready, 0);
        #4 rst_n = 1;
        @(posedge clk); #1;
        expq.push_back({1'b0, 16'd32});
        block(2, 0, N, 0);
        wait_result();

        repeat (5) begin @(posedge clk); #1; end
        check("queue_empty", 64'(expq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
